// File: rtl/hamming_pkg.sv
// Shared Hamming(21,16) code format: widths, state encoding, data-position map
// and parity membership, so encoder and decoder cannot diverge.
package hamming_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PAR_W  = 5;
  localparam int unsigned CODE_W = DATA_W + PAR_W;
  localparam int unsigned CNT_W  = 16;

  typedef logic [PAR_W-1:0]  syndrome_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYND = 2'd1,
    CORR = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Decoded word as presented to the consumer
  typedef struct packed {
    data_t     data;
    syndrome_t syndrome;
    logic      corr;
    logic      uncorr;
  } dec_out_t;

  // Code position (1-based) holding data bit idx
  function automatic logic [4:0] data_pos(input int unsigned idx);
    logic [4:0] pos;
    case (idx)
      0:       pos = 5'd3;
      1:       pos = 5'd5;
      2:       pos = 5'd6;
      3:       pos = 5'd7;
      4:       pos = 5'd9;
      5:       pos = 5'd10;
      6:       pos = 5'd11;
      7:       pos = 5'd12;
      8:       pos = 5'd13;
      9:       pos = 5'd14;
      10:      pos = 5'd15;
      11:      pos = 5'd17;
      12:      pos = 5'd18;
      13:      pos = 5'd19;
      14:      pos = 5'd20;
      15:      pos = 5'd21;
      default: pos = 5'd0;
    endcase
    return pos;
  endfunction

  // Code position pos is covered by parity bit pbit when bit pbit of pos is set
  function automatic logic parity_member(input logic [4:0] pos, input logic [2:0] pbit);
    return |(pos & (5'd1 << pbit));
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational 21-bit codeword to 5-bit syndrome (even parity, parity
// positions included). Shared with the encoder self-check.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output syndrome_t         o_syndrome
);

  always_comb begin
    o_syndrome = '0;
    for (int unsigned p = 1; p <= CODE_W; p++) begin
      for (int unsigned b = 0; b < PAR_W; b++) begin
        if (parity_member(5'(p), 3'(b))) begin
          o_syndrome[b] = o_syndrome[b] ^ i_code[p-1];
        end
      end
    end
  end

endmodule

// File: rtl/hamming_dec.sv
// Hamming(21,16) single-error-correcting decoder with valid/ready handshakes.
// Optional saturating error counters when HAMMING_DEC_STATS_EN is defined.
module hamming_dec #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [hamming_pkg::CODE_W-1:0] iData,
  input  logic                          iValid,
  output logic                          oReady,
  output logic [hamming_pkg::DATA_W-1:0] oData,
  output logic                          oValid,
  input  logic                          iReady,
  output logic                          oCorr,
  output logic                          oUncorr,
  output logic [hamming_pkg::PAR_W-1:0]  oSyndrome
`ifdef HAMMING_DEC_STATS_EN
  ,
  output logic [hamming_pkg::CNT_W-1:0]  oCorrCnt,
  output logic [hamming_pkg::CNT_W-1:0]  oUncorrCnt
`endif
);

  import hamming_pkg::*;

  if (DATA_W != hamming_pkg::DATA_W) begin : g_bad_data_w
    $error("hamming_dec: only DATA_W=16 is supported");
  end

  state_t    r_state;
  state_t    w_next;
  code_t     r_code;
  syndrome_t r_syn;
  syndrome_t w_syn;
  code_t     w_fixed;
  logic      w_flip;
  logic      w_out_range;
  dec_out_t  r_out;
  dec_out_t  w_out;
  logic      r_ready;
  logic      r_valid;
  logic      w_ready;
  logic      w_valid;

  hamming_syndrome u_syndrome (
    .i_code     (r_code),
    .o_syndrome (w_syn)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (iValid) w_next = SYND;
      SYND:    w_next = CORR;
      CORR:    w_next = HOLD;
      HOLD:    if (iReady) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Correction: flip position s for s in 1..21, leave word alone otherwise
  always_comb begin
    w_flip      = (r_syn != '0) && (r_syn <= 5'(CODE_W));
    w_out_range = (r_syn > 5'(CODE_W));
    w_fixed     = r_code;
    if (w_flip) begin
      w_fixed = r_code ^ (code_t'(1) << (r_syn - 5'd1));
    end
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    w_ready = (w_next == IDLE);
    w_valid = (w_next == HOLD);
    w_out   = r_out;
    if (r_state == CORR) begin
      for (int unsigned i = 0; i < hamming_pkg::DATA_W; i++) begin
        w_out.data[i] = w_fixed[data_pos(i) - 5'd1];
      end
      w_out.syndrome = r_syn;
      w_out.corr     = w_flip;
      w_out.uncorr   = w_out_range;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_out   <= '0;
    end else begin
      r_ready <= w_ready;
      r_valid <= w_valid;
      r_out   <= w_out;
    end
  end

  // Codeword capture and syndrome pipeline stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_code <= '0;
      r_syn  <= '0;
    end else begin
      if (r_state == IDLE && iValid) begin
        r_code <= iData;
      end
      if (r_state == SYND) begin
        r_syn <= w_syn;
      end
    end
  end

  assign oReady    = r_ready;
  assign oValid    = r_valid;
  assign oData     = r_out.data;
  assign oSyndrome = r_out.syndrome;
  assign oCorr     = r_out.corr;
  assign oUncorr   = r_out.uncorr;

`ifdef HAMMING_DEC_STATS_EN
  logic [CNT_W-1:0] r_corr_cnt;
  logic [CNT_W-1:0] r_uncorr_cnt;
  logic             w_xfer;

  assign w_xfer = r_valid && iReady;

  // Saturating counters of corrected / uncorrectable words handed to the consumer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (w_xfer) begin
      if (r_out.corr && (r_corr_cnt != '1)) begin
        r_corr_cnt <= r_corr_cnt + CNT_W'(1);
      end
      if (r_out.uncorr && (r_uncorr_cnt != '1)) begin
        r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
      end
    end
  end

  assign oCorrCnt   = r_corr_cnt;
  assign oUncorrCnt = r_uncorr_cnt;
`endif

endmodule

// File: tb/tb_hamming_dec.sv
// Scoreboard bench for hamming_dec: stimulus queues expected words and probe
// records; a negedge monitor pops and compares them.
module tb_hamming_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic [20:0] iData;
  logic        iValid;
  logic        oReady;
  logic [15:0] oData;
  logic        oValid;
  logic        iReady;
  logic        oCorr;
  logic        oUncorr;
  logic [4:0]  oSyndrome;
`ifdef HAMMING_DEC_STATS_EN
  logic [15:0] oCorrCnt;
  logic [15:0] oUncorrCnt;
`endif

  hamming_dec dut (
    .clk       (clk),
    .rst       (rst),
    .iData     (iData),
    .iValid    (iValid),
    .oReady    (oReady),
    .oData     (oData),
    .oValid    (oValid),
    .iReady    (iReady),
    .oCorr     (oCorr),
    .oUncorr   (oUncorr),
    .oSyndrome (oSyndrome)
`ifdef HAMMING_DEC_STATS_EN
    ,
    .oCorrCnt  (oCorrCnt),
    .oUncorrCnt(oUncorrCnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] data;
    logic [4:0]  syn;
    logic        corr;
    logic        uncorr;
  } exp_t;

  typedef struct {
    logic [127:0] name;
    logic [31:0]  act;
    logic [31:0]  exp;
  } chk_t;

  exp_t exp_q[$];
  chk_t chk_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   vid    = 0;
  logic m_prev_valid = 1'b0;

  task automatic cmp(input logic [127:0] nm, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %0s (vector %0d): got 0x%0h, expected 0x%0h", nm, id, act, exp);
    end
  endtask

  // Monitor: drain probe records, score each new output word
  always @(negedge clk) begin
    chk_t c;
    exp_t e;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      cmp(c.name, -1, c.act, c.exp);
    end
    if (!rst && oValid && !m_prev_valid) begin
      if (exp_q.size() == 0) begin
        cmp("unexpected_out", -1, 32'(oData), 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        cmp("oData",     e.id, 32'(oData),     32'(e.data));
        cmp("oSyndrome", e.id, 32'(oSyndrome), 32'(e.syn));
        cmp("oCorr",     e.id, 32'(oCorr),     32'(e.corr));
        cmp("oUncorr",   e.id, 32'(oUncorr),   32'(e.uncorr));
      end
    end
    m_prev_valid = oValid;
  end

  task automatic probe(input logic [127:0] nm, input logic [31:0] act, input logic [31:0] exp);
    chk_q.push_back('{nm, act, exp});
  endtask

  // Called at a negedge; returns at the negedge right after the capture edge
  task automatic send(input logic [20:0] code, input logic [15:0] d, input logic [4:0] s,
                      input logic c, input logic u, input bit track);
    int n = 0;
    while (!oReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    probe("ready_wait", 32'(oReady), 32'd1);
    if (track) exp_q.push_back('{vid, d, s, c, u});
    vid++;
    iData  = code;
    iValid = 1'b1;
    @(negedge clk);
    iValid = 1'b0;
  endtask

  // Samples after the capture edge until oValid is seen (3 = three edges incl. capture)
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!oValid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    probe("valid_wait", 32'(oValid), 32'd1);
  endtask

  task automatic release_out();
    iReady = 1'b1;
    @(negedge clk);
    iReady = 1'b0;
  endtask

  task automatic run(input logic [20:0] code, input logic [15:0] d, input logic [4:0] s,
                     input logic c, input logic u);
    int lat;
    send(code, d, s, c, u, 1'b1);
    wait_valid(lat);
    release_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          unstable;
    int          rdy_hi;
    int          val_lo;
    logic [15:0] held;

    rst    = 1'b1;
    iData  = '0;
    iValid = 1'b0;
    iReady = 1'b0;
    repeat (3) @(negedge clk);
    probe("rst_oReady",    32'(oReady),    32'd1);
    probe("rst_oValid",    32'(oValid),    32'd0);
    probe("rst_oData",     32'(oData),     32'd0);
    probe("rst_oCorr",     32'(oCorr),     32'd0);
    probe("rst_oUncorr",   32'(oUncorr),   32'd0);
    probe("rst_oSyndrome", 32'(oSyndrome), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Clean word and output latency
    send(21'h08C3E6, 16'h443D, 5'd0, 1'b0, 1'b0, 1'b1);
    wait_valid(lat);
    probe("latency", 32'(lat), 32'd3);
    release_out();
    probe("post_rel_oValid", 32'(oValid), 32'd0);
    probe("post_rel_oReady", 32'(oReady), 32'd1);

    // Single errors: data, parity, first and last positions
    run(21'h08C3A6, 16'h443D, 5'd7,  1'b1, 1'b0);
    run(21'h0843E6, 16'h443D, 5'd16, 1'b1, 1'b0);
    run(21'h08C3E7, 16'h443D, 5'd1,  1'b1, 1'b0);
    run(21'h18C3E6, 16'h443D, 5'd21, 1'b1, 1'b0);
    // Double error with syndrome out of range
    run(21'h084366, 16'h443D, 5'd24, 1'b0, 1'b1);
    // Other data patterns
    run(21'h000000, 16'h0000, 5'd0,  1'b0, 1'b0);
    run(21'h1FF7FE, 16'hFFFF, 5'd12, 1'b1, 1'b0);
    // Double error (positions 1,2) miscorrected at position 3
    run(21'h000003, 16'h0001, 5'd3,  1'b1, 1'b0);

    // Back-pressure: outputs hold, second word is dropped
    send(21'h1FFFFE, 16'hFFFF, 5'd0, 1'b0, 1'b0, 1'b1);
    wait_valid(lat);
    held     = oData;
    unstable = 0;
    rdy_hi   = 0;
    val_lo   = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        iData  = 21'h08C3E6;
        iValid = 1'b1;
      end else begin
        iValid = 1'b0;
      end
      @(negedge clk);
      if (oData !== held) unstable++;
      if (oReady) rdy_hi++;
      if (!oValid) val_lo++;
    end
    iValid = 1'b0;
    probe("hold_stable",   32'(unstable), 32'd0);
    probe("hold_oReady",   32'(rdy_hi),   32'd0);
    probe("hold_oValid",   32'(val_lo),   32'd0);
    release_out();
    probe("rel_oValid", 32'(oValid), 32'd0);
    probe("rel_oReady", 32'(oReady), 32'd1);
    repeat (6) @(negedge clk);
    probe("dropped_word", 32'(oValid), 32'd0);

    // Reset while in CORR
    send(21'h08C3A6, 16'h443D, 5'd7, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    probe("mid_rst_oValid",    32'(oValid),    32'd0);
    probe("mid_rst_oReady",    32'(oReady),    32'd1);
    probe("mid_rst_oData",     32'(oData),     32'd0);
    probe("mid_rst_oSyndrome", 32'(oSyndrome), 32'd0);
    probe("mid_rst_oCorr",     32'(oCorr),     32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    probe("mid_rst_no_out", 32'(oValid), 32'd0);

`ifdef HAMMING_DEC_STATS_EN
    probe("corr_cnt_rst",   32'(oCorrCnt),   32'd0);
    probe("uncorr_cnt_rst", 32'(oUncorrCnt), 32'd0);
    run(21'h08C3A6, 16'h443D, 5'd7,  1'b1, 1'b0);
    run(21'h08C3E2, 16'h443D, 5'd3,  1'b1, 1'b0);
    run(21'h18C3E6, 16'h443D, 5'd21, 1'b1, 1'b0);
    run(21'h084366, 16'h443D, 5'd24, 1'b0, 1'b1);
    run(21'h08C3E6, 16'h443D, 5'd0,  1'b0, 1'b0);
    @(negedge clk);
    probe("corr_cnt",   32'(oCorrCnt),   32'd3);
    probe("uncorr_cnt", 32'(oUncorrCnt), 32'd1);
`endif

    repeat (2) @(negedge clk);
    probe("pending_outputs", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
